// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial word link: frame width, FSM states, and the receiver
// idle word that benches use.
package serial_link_pkg;

    localparam int unsigned LINK_WIDTH = 16;
    localparam logic [LINK_WIDTH-1:0] LINK_IDLE_WORD = 16'hF800;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } tx_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period down-counter for the serial transmitter. bit_tick is registered and marks the
// last cycle of each bit period; tick_next is its next-state value.
module serial_bit_timer
    import serial_link_pkg::*;
#(
    parameter int unsigned BIT_DIV = 1
) (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic start,
    input  logic run,
    output logic bit_tick,
    output logic tick_next
);

    localparam int unsigned CW = cnt_width(BIT_DIV);
    localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    // A new word, or a fresh period after reaching zero, reloads the full period length.
    always_comb begin
        cnt_d = LAST;
        if (!start && run) begin
            cnt_d = (cnt_q == '0) ? LAST : cnt_q - 1'b1;
        end
        tick_next = run && (cnt_d == '0);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q  <= LAST;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_next;
        end
    end

    assign bit_tick = tick_q;

endmodule

// File: rtl/serial_word_tx.sv
// Transmit end of the serial word link: accepts words on valid/ready, buffers one pending
// word, and shifts each out LSB first on DATA with one ENABLE strobe per bit.
module serial_word_tx
    import serial_link_pkg::*;
#(
    parameter int unsigned WIDTH      = LINK_WIDTH,
    parameter int unsigned BIT_DIV    = 1,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] WORD_IN,
    input  logic             WORD_VALID,
    output logic             WORD_READY,
    output logic             DATA,
    output logic             ENABLE,
    output logic             BUSY,
    output logic [CNT_W-1:0] WORDS_SENT
);

    localparam int unsigned IW = cnt_width(WIDTH + 1);
    localparam int unsigned GW = cnt_width(GAP_CYCLES);
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [IW-1:0]    bit_idx_q, bit_idx_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             busy_q;

    logic bit_tick, tick_next;
    logic accept, last_bit, gap_done;
    logic word_slot, load_hold, load_in, start, run;

    assign accept   = WORD_VALID & ~hold_full_q;
    assign last_bit = (state_q == SHIFT) & bit_tick & (bit_idx_q == LAST_BIT);
    assign gap_done = (state_q == GAP) & (gap_cnt_q == LAST_GAP);
    assign run      = (state_d == SHIFT);

    serial_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_timer (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .start     (start),
        .run       (run),
        .bit_tick  (bit_tick),
        .tick_next (tick_next)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    if (HAS_GAP) state_d = GAP;
                    else         state_d = start ? SHIFT : IDLE;
                end
            end
            GAP:     if (gap_done) state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A word slot is any cycle whose closing edge may begin a new word; the pending word wins,
    // otherwise an incoming word bypasses the hold buffer.
    always_comb begin
        word_slot = 1'b0;
        unique case (state_q)
            IDLE:    word_slot = 1'b1;
            SHIFT:   word_slot = last_bit & ~HAS_GAP;
            GAP:     word_slot = gap_done;
            default: word_slot = 1'b0;
        endcase
        load_hold = word_slot & hold_full_q;
        load_in   = word_slot & ~hold_full_q & accept;
        start     = load_hold | load_in;
    end

    always_comb begin
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        if (load_hold) begin
            shift_d   = hold_q;
            bit_idx_d = '0;
        end else if (load_in) begin
            shift_d   = WORD_IN;
            bit_idx_d = '0;
        end else if ((state_q == SHIFT) && bit_tick) begin
            // Zero fill leaves DATA low once the word has fully drained.
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
        end

        hold_d      = hold_q;
        hold_full_d = hold_full_q & ~load_hold;
        if (accept && !load_in) begin
            hold_d      = WORD_IN;
            hold_full_d = 1'b1;
        end

        gap_cnt_d = ((state_q == GAP) && !gap_done) ? gap_cnt_q + 1'b1 : '0;

        // Count lands together with the final strobe of the word.
        words_d = words_q;
        if (tick_next && (bit_idx_d == LAST_BIT)) begin
            words_d = words_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_idx_q   <= '0;
            gap_cnt_q   <= '0;
            words_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_idx_q   <= bit_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            words_q     <= words_d;
            busy_q      <= (state_d != IDLE) | hold_full_d;
        end
    end

    assign WORD_READY = ~hold_full_q;
    assign DATA       = shift_q[0];
    assign ENABLE     = bit_tick;
    assign BUSY       = busy_q;
    assign WORDS_SENT = words_q;

endmodule
